v13_peak_detector: RTL and testbench

//  Downstream stage of the v13 cusp-like shaping filter. Watches the shaped

---
 rtl/v13_peak_detector.sv | 143 ++++++++++++++
 tb/tb_v13_peak_detector.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/v13_peak_detector.sv
// Peak detector for the v13 shaped stream: one event (amp/time/width/pileup) per pulse.
// Latency: event visible on the clock edge that samples the pulse-ending sample.
// Backpressure: 1-entry event register; an emit while it is full and not being read is dropped and counted.
module v13_peak_detector #(
  parameter int DATA_W  = 17,
  parameter int TS_W    = 32,
  parameter int MAX_W   = 64,
  parameter int HOLDOFF = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] threshold,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic signed [DATA_W-1:0] evt_amp,
  output logic [TS_W-1:0]          evt_time,
  output logic [7:0]               evt_width,
  output logic                     evt_pileup,
  output logic [15:0]              lost_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ABOVE   = 2'd1;
  localparam logic [1:0] S_HOLDOFF = 2'd2;

  localparam int          HC_W    = $clog2(HOLDOFF) + 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLDOFF - 1);
  localparam logic [7:0]  MAX_W8  = 8'(MAX_W);

  logic [1:0]               state;
  logic [TS_W-1:0]          ts;
  logic signed [DATA_W-1:0] peak;
  logic [TS_W-1:0]          peak_ts;
  logic [7:0]               width;
  logic [HC_W-1:0]          hcnt;
  logic                     pileup_pend;

  logic above;
  logic at_max;
  logic emit;
  logic emit_pileup;

  // Decode whether the current valid sample ends the running pulse.
  always_comb begin
    above       = in_data > threshold;
    at_max      = (width == MAX_W8);
    emit        = 1'b0;
    emit_pileup = at_max | pileup_pend;
    if (in_valid && state == S_ABOVE && (!above || at_max)) begin
      emit = 1'b1;
    end
  end

  // Free-running timestamp, counts every clock regardless of in_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  // Pulse tracking: IDLE -> ABOVE -> HOLDOFF, advancing only on valid samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      peak        <= '0;
      peak_ts     <= '0;
      width       <= '0;
      hcnt        <= '0;
      pileup_pend <= 1'b0;
    end else if (in_valid) begin
      case (state)
        S_IDLE: begin
          if (above) begin
            state   <= S_ABOVE;
            peak    <= in_data;
            peak_ts <= ts;
            width   <= 8'd1;
          end
        end
        S_ABOVE: begin
          if (emit) begin
            // Ending sample is neither counted nor compared against the peak.
            state       <= S_HOLDOFF;
            hcnt        <= '0;
            pileup_pend <= 1'b0;
          end else begin
            width <= width + 8'd1;
            if (in_data > peak) begin
              peak    <= in_data;
              peak_ts <= ts;
            end
          end
        end
        S_HOLDOFF: begin
          if (hcnt == HC_LAST) begin
            if (above) begin
              // Pulse already high when holdoff expires: start it now, flag as pileup.
              state       <= S_ABOVE;
              peak        <= in_data;
              peak_ts     <= ts;
              width       <= 8'd1;
              pileup_pend <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            hcnt <= hcnt + HC_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // One-entry event register with valid/ready handoff and saturating drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_valid  <= 1'b0;
      evt_amp    <= '0;
      evt_time   <= '0;
      evt_width  <= '0;
      evt_pileup <= 1'b0;
      lost_cnt   <= '0;
    end else if (emit) begin
      if (!evt_valid || evt_ready) begin
        evt_valid  <= 1'b1;
        evt_amp    <= peak;
        evt_time   <= peak_ts;
        evt_width  <= width;
        evt_pileup <= emit_pileup;
      end else if (lost_cnt != 16'hFFFF) begin
        lost_cnt <= lost_cnt + 16'd1;
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_v13_peak_detector.sv
// Self-checking bench for v13_peak_detector: directed pulse scenarios plus random traffic.
// Every cycle all outputs are compared against a pulse-level reference model.
module tb_v13_peak_detector;

  localparam int MAX_W   = 64;
  localparam int HOLDOFF = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic signed [16:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic signed [16:0] threshold = 17'sd100;
  logic               evt_valid;
  logic               evt_ready = 1'b1;
  logic signed [16:0] evt_amp;
  logic [31:0]        evt_time;
  logic [7:0]         evt_width;
  logic               evt_pileup;
  logic [15:0]        lost_cnt;

  int errors = 0;
  int checks = 0;

  v13_peak_detector dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .threshold(threshold), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_amp(evt_amp), .evt_time(evt_time), .evt_width(evt_width),
    .evt_pileup(evt_pileup), .lost_cnt(lost_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: pulse kept as a list of (sample, timestamp); peak found at pulse end.
  int                 m_mode;      // 0 waiting, 1 in pulse, 2 holdoff
  logic signed [16:0] pq[$];
  logic [31:0]        tq[$];
  int                 m_hold_seen;
  bit                 m_pend;
  logic [31:0]        m_ts;
  logic               m_vld;
  logic signed [16:0] m_amp;
  logic [31:0]        m_time;
  logic [7:0]         m_width;
  logic               m_pile;
  logic [15:0]        m_lost;

  task automatic model_reset();
    m_mode = 0; pq.delete(); tq.delete(); m_hold_seen = 0; m_pend = 0; m_ts = '0;
    m_vld = 0; m_amp = '0; m_time = '0; m_width = '0; m_pile = 0; m_lost = '0;
  endtask

  task automatic model_step(input logic v, input logic signed [16:0] d,
                            input logic signed [16:0] thr, input logic rdy);
    bit                 emit_now = 0;
    bit                 a;
    logic signed [16:0] best;
    int                 idx;
    logic signed [16:0] e_amp = '0;
    logic [31:0]        e_time = '0;
    int                 e_width = 0;
    bit                 e_pile = 0;
    if (v) begin
      a = (d > thr);
      if (m_mode == 1) begin
        if (!a || pq.size() == MAX_W) begin
          best = pq[0]; idx = 0;
          foreach (pq[i]) if (pq[i] > best) begin best = pq[i]; idx = i; end
          e_amp = best; e_time = tq[idx]; e_width = pq.size();
          e_pile = (pq.size() == MAX_W) || m_pend;
          emit_now = 1; m_pend = 0; m_mode = 2; m_hold_seen = 0;
          pq.delete(); tq.delete();
        end else begin
          pq.push_back(d); tq.push_back(m_ts);
        end
      end else if (m_mode == 0) begin
        if (a) begin pq.push_back(d); tq.push_back(m_ts); m_mode = 1; end
      end else begin
        m_hold_seen++;
        if (m_hold_seen == HOLDOFF) begin
          if (a) begin pq.push_back(d); tq.push_back(m_ts); m_mode = 1; m_pend = 1; end
          else m_mode = 0;
        end
      end
    end
    if (emit_now) begin
      if (!m_vld || rdy) begin
        m_vld = 1; m_amp = e_amp; m_time = e_time; m_width = 8'(e_width); m_pile = e_pile;
      end else if (m_lost != 16'hFFFF) begin
        m_lost = m_lost + 16'd1;
      end
    end else if (m_vld && rdy) begin
      m_vld = 0;
    end
    m_ts = m_ts + 32'd1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("evt_valid", 64'(evt_valid), 64'(m_vld));
    chk("evt_amp", evt_amp, m_amp);
    chk("evt_time", 64'(evt_time), 64'(m_time));
    chk("evt_width", 64'(evt_width), 64'(m_width));
    chk("evt_pileup", 64'(evt_pileup), 64'(m_pile));
    chk("lost_cnt", 64'(lost_cnt), 64'(m_lost));
  endtask

  // One clock: drive inputs, advance model, sample outputs 1 time unit after the edge.
  task automatic cycle(input logic v, input logic signed [16:0] d, input logic rdy);
    in_valid = v; in_data = d; evt_ready = rdy;
    model_step(v, d, threshold, rdy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_all();
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0]        t0;
    logic signed [16:0] neg20;
    int                 r;
    logic signed [16:0] rd;

    // Reset state
    do_reset();
    chk("rst_valid", 64'(evt_valid), 64'd0);
    chk("rst_lost", 64'(lost_cnt), 64'd0);

    // Basic pulse on ts 10..14
    threshold = 17'sd100;
    repeat (10) cycle(1'b1, 17'sd0, 1'b1);
    cycle(1'b1, 17'sd0, 1'b1);
    cycle(1'b1, 17'sd150, 1'b1);
    cycle(1'b1, 17'sd300, 1'b1);
    cycle(1'b1, 17'sd250, 1'b1);
    chk("basic_not_yet", 64'(evt_valid), 64'd0);
    cycle(1'b1, 17'sd80, 1'b1);
    chk("basic_valid", 64'(evt_valid), 64'd1);
    chk("basic_amp", 64'(evt_amp), 64'd300);
    chk("basic_time", 64'(evt_time), 64'd12);
    chk("basic_width", 64'(evt_width), 64'd3);
    chk("basic_pile", 64'(evt_pileup), 64'd0);
    cycle(1'b1, 17'sd0, 1'b1);
    chk("basic_taken", 64'(evt_valid), 64'd0);

    // Plateau: first of equal samples wins, invalid cycles hold state
    repeat (20) cycle(1'b1, 17'sd0, 1'b1);
    t0 = m_ts;
    cycle(1'b1, 17'sd200, 1'b1);
    cycle(1'b0, 17'sd900, 1'b1);
    cycle(1'b1, 17'sd200, 1'b1);
    cycle(1'b1, 17'sd200, 1'b1);
    cycle(1'b1, 17'sd0, 1'b1);
    chk("plat_amp", 64'(evt_amp), 64'd200);
    chk("plat_time", 64'(evt_time), 64'(t0));
    chk("plat_width", 64'(evt_width), 64'd3);

    // Negative threshold, signed compare
    repeat (20) cycle(1'b1, 17'sd0, 1'b1);
    threshold = -17'sd50;
    cycle(1'b1, -17'sd100, 1'b1);
    cycle(1'b1, -17'sd20, 1'b1);
    cycle(1'b1, -17'sd60, 1'b1);
    neg20 = -17'sd20;
    chk("neg_amp", evt_amp, neg20);
    chk("neg_width", 64'(evt_width), 64'd1);

    // Long pulse hits MAX_W, then restarts on holdoff expiry
    threshold = 17'sd100;
    repeat (20) cycle(1'b1, 17'sd0, 1'b1);
    for (int j = 1; j <= 90; j++) begin
      cycle(1'b1, 17'sd500, 1'b1);
      if (j == MAX_W + 1) begin
        chk("max_valid", 64'(evt_valid), 64'd1);
        chk("max_width", 64'(evt_width), 64'd64);
        chk("max_pile", 64'(evt_pileup), 64'd1);
      end
    end
    cycle(1'b1, 17'sd0, 1'b1);
    chk("pile2_valid", 64'(evt_valid), 64'd1);
    chk("pile2_width", 64'(evt_width), 64'd10);
    chk("pile2_pile", 64'(evt_pileup), 64'd1);

    // Held event, second event dropped
    repeat (20) cycle(1'b1, 17'sd0, 1'b1);
    cycle(1'b1, 17'sd200, 1'b0);
    cycle(1'b1, 17'sd0, 1'b0);
    repeat (20) cycle(1'b1, 17'sd0, 1'b0);
    cycle(1'b1, 17'sd300, 1'b0);
    cycle(1'b1, 17'sd0, 1'b0);
    chk("drop_amp", 64'(evt_amp), 64'd200);
    chk("drop_lost", 64'(lost_cnt), 64'd1);
    cycle(1'b1, 17'sd0, 1'b1);
    chk("drop_taken", 64'(evt_valid), 64'd0);

    // Emit and accept on the same edge
    do_reset();
    repeat (5) cycle(1'b1, 17'sd0, 1'b1);
    cycle(1'b1, 17'sd200, 1'b0);
    cycle(1'b1, 17'sd0, 1'b0);
    repeat (20) cycle(1'b1, 17'sd0, 1'b0);
    cycle(1'b1, 17'sd300, 1'b0);
    cycle(1'b1, 17'sd0, 1'b1);
    chk("same_valid", 64'(evt_valid), 64'd1);
    chk("same_amp", 64'(evt_amp), 64'd300);
    chk("same_lost", 64'(lost_cnt), 64'd0);

    // Reset asserted mid-pulse: outputs clear immediately, nothing emitted afterwards
    repeat (20) cycle(1'b1, 17'sd0, 1'b1);
    cycle(1'b1, 17'sd300, 1'b1);
    cycle(1'b1, 17'sd300, 1'b1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 64'(evt_valid), 64'd0);
    chk("arst_amp", 64'(evt_amp), 64'd0);
    chk("arst_width", 64'(evt_width), 64'd0);
    do_reset();
    repeat (30) cycle(1'b1, 17'sd0, 1'b1);

    // Random traffic
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if (k % 300 == 0) begin
        r = $urandom_range(0, 200) - 100;
        threshold = 17'(r);
      end
      r = $urandom_range(0, 600) - 300;
      rd = 17'(r);
      cycle(($urandom_range(0, 9) < 8), rd, ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
